// File: rtl/crc5_token_tx.sv
//==============================================================================
// Module      : crc5_token_tx
// Description : USB token serializer. Sends the DATA_W-bit payload LSB-first,
//               then the inverted CRC5 (x^5+x^2+1, seed 5'h1F) MSB-first.
//               Optional macro CRC5_SELFCHK_EN adds a receive-side residual
//               checker on the transmitted stream (output selfchk_fail).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module crc5_token_tx #(
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              shift_en,
  output logic              serial_out,
  output logic              ready,
  output logic              busy,
  output logic              done
`ifdef CRC5_SELFCHK_EN
  ,
  output logic              selfchk_fail
`endif
);

  // Counter must also reach the CRC terminal count of 4, even for tiny DATA_W.
  localparam int CW = ($clog2(DATA_W) < 3) ? 3 : $clog2(DATA_W);

  localparam logic [4:0]    c_SEED      = 5'h1F;
  localparam logic [4:0]    c_POLY      = 5'b00101;
  localparam logic [4:0]    c_RESIDUAL  = 5'b01100;
  localparam logic [CW-1:0] c_DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] c_CRC_LAST  = CW'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CRC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_sr;
  logic [DATA_W-1:0] w_sr_nxt;
  logic [4:0]        r_crc;
  logic [4:0]        w_crc_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              r_serial_out;
  logic              w_serial_nxt;
  logic              w_fb;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_sr         <= '0;
      r_crc        <= c_SEED;
      r_cnt        <= '0;
      r_serial_out <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_sr         <= w_sr_nxt;
      r_crc        <= w_crc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_serial_out <= w_serial_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sr_nxt     = r_sr;
    w_crc_nxt    = r_crc;
    w_cnt_nxt    = r_cnt;
    w_serial_nxt = 1'b1;
    w_fb         = r_crc[4] ^ r_sr[0];

    if (clear) begin
      w_state_nxt = S_IDLE;
      w_crc_nxt   = c_SEED;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            w_sr_nxt    = data_in;
            w_crc_nxt   = c_SEED;
            w_cnt_nxt   = '0;
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (shift_en) begin
            w_crc_nxt = {r_crc[3:0], 1'b0} ^ (w_fb ? c_POLY : 5'b00000);
            w_sr_nxt  = r_sr >> 1;
            if (r_cnt == c_DATA_LAST) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_CRC;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        S_CRC: begin
          if (shift_en) begin
            w_crc_nxt = {r_crc[3:0], 1'b0};
            if (r_cnt == c_CRC_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // The line bit is registered, so it is derived from the upcoming state.
    case (w_state_nxt)
      S_DATA:  w_serial_nxt = w_sr_nxt[0];
      S_CRC:   w_serial_nxt = ~w_crc_nxt[4];
      default: w_serial_nxt = 1'b1;
    endcase
  end

  assign serial_out = r_serial_out;
  assign ready      = (r_state == S_IDLE);
  assign busy       = (r_state == S_DATA) || (r_state == S_CRC);
  assign done       = (r_state == S_DONE);

`ifdef CRC5_SELFCHK_EN
  logic [4:0] r_chk;
  logic       r_selfchk_fail;
  logic       w_chk_fb;

  assign w_chk_fb = r_chk[4] ^ r_serial_out;

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      r_chk          <= c_SEED;
      r_selfchk_fail <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_chk          <= c_SEED;
            r_selfchk_fail <= 1'b0;
          end
        end
        S_DATA, S_CRC: begin
          if (shift_en) begin
            r_chk <= {r_chk[3:0], 1'b0} ^ (w_chk_fb ? c_POLY : 5'b00000);
          end
        end
        S_DONE: begin
          r_selfchk_fail <= (r_chk != c_RESIDUAL);
        end
        default: begin
          r_chk <= r_chk;
        end
      endcase
    end
  end

  assign selfchk_fail = r_selfchk_fail;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc5_token_tx.sv
//==============================================================================
// Module      : tb_crc5_token_tx
// Description : Scoreboard bench for crc5_token_tx with a bit-level CRC5 model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_crc5_token_tx;

  localparam int DATA_W = 11;
  localparam int TOK_W  = DATA_W + 5;

  typedef bit bitq_t[$];
  typedef struct {
    bit b;
    bit last;
  } exp_t;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              clear;
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              shift_en;
  logic              serial_out;
  logic              ready;
  logic              busy;
  logic              done;
`ifdef CRC5_SELFCHK_EN
  logic              selfchk_fail;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          mode  = 1;
  exp_t        expq[$];
  bitq_t       rx;
  logic [15:0] last_stream = '0;

  crc5_token_tx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (clear),
    .load       (load),
    .data_in    (data_in),
    .shift_en   (shift_en),
    .serial_out (serial_out),
    .ready      (ready),
    .busy       (busy),
    .done       (done)
`ifdef CRC5_SELFCHK_EN
    ,
    .selfchk_fail (selfchk_fail)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // USB CRC5 over a bit sequence in transmission order, as plain integer arithmetic.
  function automatic int crc_over(input bitq_t q);
    int r = 31;
    foreach (q[i]) begin
      if ((((r >> 4) & 1) ^ int'(q[i])) != 0) r = ((r << 1) ^ 5) & 31;
      else                                    r = (r << 1) & 31;
    end
    return r;
  endfunction

  // Expected line stream: bit i of the result is the i-th bit on the wire.
  function automatic logic [15:0] token_bits(input logic [DATA_W-1:0] d);
    bitq_t       msg;
    int          c;
    logic [15:0] s;
    for (int i = 0; i < DATA_W; i++) begin
      msg.push_back(d[i]);
      s[i] = d[i];
    end
    c = crc_over(msg);
    for (int k = 0; k < 5; k++) s[DATA_W + k] = ~c[4 - k];
    return s;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    int          t = 0;
    logic [15:0] s;
    exp_t        e;
    while (!ready && t < 2000) begin
      step();
      t++;
    end
    if (!ready) begin
      chk("ready_timeout", 32'(ready), 32'd1);
      return;
    end
    s = token_bits(d);
    for (int i = 0; i < TOK_W; i++) begin
      e.b    = s[i];
      e.last = (i == TOK_W - 1);
      expq.push_back(e);
    end
    load    = 1'b1;
    data_in = d;
    step();
    load    = 1'b0;
    data_in = DATA_W'($urandom);
  endtask

  task automatic wait_done;
    int t = 0;
    while ((expq.size() != 0 || !ready) && t < 3000) begin
      step();
      t++;
    end
    if (expq.size() != 0 || !ready) chk("token_timeout", 32'(expq.size()), 32'd0);
  endtask

  // Bit strobe generator: 1 = every cycle, 4 = every 4th cycle, 2 = random.
  initial begin
    int div = 0;
    shift_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1:       shift_en = 1'b1;
        4:       begin div++; shift_en = ((div % 4) == 0); end
        default: shift_en = (($urandom % 3) != 0);
      endcase
    end
  end

  // Monitor: checks every presented bit against the queue head, pops on consumption.
  initial begin
    bit   exp_done  = 0;
    bit   prev_done = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        expq.delete();
        rx.delete();
        exp_done  = 0;
        prev_done = 0;
        continue;
      end
      if (done || exp_done) chk("done_pulse", 32'(done), 32'(exp_done));
      if (prev_done) begin
        chk("ready_after_done", 32'(ready), 32'd1);
`ifdef CRC5_SELFCHK_EN
        chk("selfchk_fail", 32'(selfchk_fail), 32'd0);
`endif
      end
      prev_done = done;
      exp_done  = 0;
      if (ready) chk("idle_serial_out", 32'(serial_out), 32'd1);
      if (busy) begin
        if (expq.size() == 0) begin
          chk("busy_without_token", 32'(busy), 32'd0);
        end else begin
          chk("serial_bit", 32'(serial_out), 32'(expq[0].b));
          if (shift_en && !clear) begin
            e = expq.pop_front();
            rx.push_back(serial_out);
            if (e.last) begin
              exp_done = 1;
              chk("residual", 32'(crc_over(rx)), 32'h0C);
              for (int i = 0; i < TOK_W; i++) last_stream[i] = rx[i];
              rx.delete();
            end
          end
        end
      end
      if (clear) begin
        expq.delete();
        rx.delete();
        exp_done = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] a;
    n_rst   = 1'b0;
    clear   = 1'b0;
    load    = 1'b0;
    data_in = '0;
    mode    = 1;
    repeat (3) step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_serial_out", 32'(serial_out), 32'd1);
    n_rst = 1'b1;
    repeat (10) step();
    chk("idle_ready", 32'(ready), 32'd1);

    send(11'h000);
    wait_done();
    chk("zero_stream_fast", 32'(last_stream), 32'h1000);

    mode = 4;
    send(11'h000);
    wait_done();
    chk("zero_stream_slow", 32'(last_stream), 32'h1000);

    mode = 1;
    send(11'h7FF);
    repeat (6) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_ready", 32'(ready), 32'd1);
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_serial_out", 32'(serial_out), 32'd1);
    send(11'h7FF);
    wait_done();
    chk("after_clear_stream", 32'(last_stream), 32'(token_bits(11'h7FF)));

    mode = 2;
    a = 11'h2A5;
    send(a);
    repeat (3) step();
    load    = 1'b1;
    data_in = ~a;
    repeat (2) step();
    load = 1'b0;
    wait_done();
    chk("load_ignored_stream", 32'(last_stream), 32'(token_bits(a)));

    send(DATA_W'($urandom));
    repeat (7) step();
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_serial_out", 32'(serial_out), 32'd1);

    for (int n = 0; n < 200; n++) begin
      send(DATA_W'($urandom));
      if ((n % 8) == 7) wait_done();
    end
    wait_done();
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
